// File: rtl/regfile_sequencer.sv
// Bit-serial ALU sequencer: streams rs1/rs2 through the serial ALU into a buffer, then writes the buffer back to rd.
// Optional REGSEQ_SKIP_EN: skip the WRITE phase when no result will be written.
module regfile_sequencer #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SEL_W-1:0]         rs1,
  input  logic [SEL_W-1:0]         rs2,
  input  logic [SEL_W-1:0]         rd,
  input  logic                     wb_en,
  input  logic                     alu_bit,
  output logic [SEL_W-1:0]         regA_select,
  output logic [SEL_W-1:0]         regB_select,
  output logic [$clog2(XLEN)-1:0]  bitPos,
  output logic                     writeEn,
  output logic                     data_in,
  output logic                     bit_first,
  output logic                     bit_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  buffer;
  logic [SEL_W-1:0] rs1_q;
  logic [SEL_W-1:0] rs2_q;
  logic [SEL_W-1:0] rd_q;
  logic             wb_en_q;
  logic             do_write;

  // x0 is hardwired zero, so it is never a write target
  assign do_write = wb_en_q && (rd_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      buffer  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            wb_en_q <= wb_en;
            cnt     <= '0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          buffer[cnt] <= alu_bit;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef REGSEQ_SKIP_EN
            state <= do_write ? S_WRITE : S_DONE;
`else
            state <= S_WRITE;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state alone, so an async reset clears them at once
  always_comb begin
    regA_select = '0;
    regB_select = '0;
    writeEn     = 1'b0;
    data_in     = 1'b0;
    bit_first   = 1'b0;
    bit_last    = 1'b0;
    case (state)
      S_READ: begin
        regA_select = rs1_q;
        regB_select = rs2_q;
        bit_first   = (cnt == '0);
        bit_last    = (cnt == CNT_LAST);
      end
      S_WRITE: begin
        regA_select = rd_q;
        data_in     = buffer[cnt];
        writeEn     = do_write;
      end
      default: begin
      end
    endcase
  end

  assign bitPos = cnt;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench for regfile_sequencer: a behavioural register file plus serial ALU surround the DUT,
// and a word-level model predicts register contents, latency and strobe timing.
module tb_regfile_sequencer;

  localparam int XLEN     = 32;
  localparam int SEL_W    = 5;
  localparam int NREG     = 32;
  localparam int LAT_FULL = 2 * XLEN + 1;
  localparam int LAT_SKIP = XLEN + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SEL_W-1:0] rs1;
  logic [SEL_W-1:0] rs2;
  logic [SEL_W-1:0] rd;
  logic             wb_en;
  logic             alu_bit;
  logic [SEL_W-1:0] regA_select;
  logic [SEL_W-1:0] regB_select;
  logic [4:0]       bitPos;
  logic             writeEn;
  logic             data_in;
  logic             bit_first;
  logic             bit_last;
  logic             busy;
  logic             done;

  logic [XLEN-1:0] regs    [NREG];
  logic [XLEN-1:0] expRegs [NREG];
  logic            loadAll = 1'b0;
  int              aluSel  = 0;
  int              checks  = 0;
  int              errors  = 0;

  regfile_sequencer #(.XLEN(XLEN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wb_en(wb_en), .alu_bit(alu_bit), .regA_select(regA_select),
    .regB_select(regB_select), .bitPos(bitPos), .writeEn(writeEn),
    .data_in(data_in), .bit_first(bit_first), .bit_last(bit_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bit-serial register file; loadAll restores it to the model's image
  always @(posedge clk) begin
    if (loadAll) begin
      for (int i = 0; i < NREG; i++) regs[i] <= expRegs[i];
    end else if (writeEn) begin
      regs[regA_select][bitPos] <= data_in;
    end
  end

  always_comb begin
    case (aluSel)
      0:       alu_bit = regs[regA_select][bitPos] ^ regs[regB_select][bitPos];
      1:       alu_bit = regs[regA_select][bitPos];
      2:       alu_bit = regs[regA_select][bitPos] & regs[regB_select][bitPos];
      default: alu_bit = regs[regA_select][bitPos] | regs[regB_select][bitPos];
    endcase
  end

  function automatic logic [XLEN-1:0] aluWord(int sel, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (sel)
      0:       return a ^ b;
      1:       return a;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomSeeds();
    expRegs[0] = '0;
    for (int i = 1; i < NREG; i++) expRegs[i] = $urandom;
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic loadSeeds();
    loadAll = 1'b1;
    @(negedge clk);
    loadAll = 1'b0;
  endtask

  // One operation; abortAt != 0 asserts reset in that cycle and abandons the operation
  task automatic applyStimulus(input logic [SEL_W-1:0] s1, input logic [SEL_W-1:0] s2,
                               input logic [SEL_W-1:0] d, input logic wb, input int sel,
                               input int abortAt);
    int doneCyc, firstCnt, firstCyc, lastCnt, lastCyc, weCnt, busyLow, expLat, diff;
    logic doWrite;
    logic [XLEN-1:0] result;
    doWrite = wb && (d != '0);
    expLat  = LAT_FULL;
`ifdef REGSEQ_SKIP_EN
    if (!doWrite) expLat = LAT_SKIP;
`endif
    result   = aluWord(sel, expRegs[s1], expRegs[s2]);
    doneCyc  = 0; firstCnt = 0; firstCyc = 0; lastCnt = 0; lastCyc = 0;
    weCnt    = 0; busyLow  = 0;
    aluSel = sel; rs1 = s1; rs2 = s2; rd = d; wb_en = wb; start = 1'b1;
    for (int cyc = 1; cyc <= LAT_FULL + 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      rs1   = SEL_W'($urandom);
      rs2   = SEL_W'($urandom);
      rd    = SEL_W'($urandom);
      wb_en = 1'($urandom);
      if (abortAt != 0 && cyc == abortAt) begin
        checkOutput("writeEnBeforeAbort", {31'd0, writeEn}, {31'd0, doWrite});
        rst = 1'b1;
        #1;
        checkOutput("outputsOnAbort", {29'd0, writeEn, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (bit_first) begin firstCnt++; if (firstCyc == 0) firstCyc = cyc; end
      if (bit_last) begin lastCnt++; if (lastCyc == 0) lastCyc = cyc; end
      if (writeEn) weCnt++;
      if (!busy) busyLow++;
      if (done) begin doneCyc = cyc; break; end
    end
    checkOutput("latency", doneCyc, expLat);
    checkOutput("bitFirstCycle", firstCyc, 1);
    checkOutput("bitFirstCount", firstCnt, 1);
    checkOutput("bitLastCycle", lastCyc, XLEN);
    checkOutput("bitLastCount", lastCnt, 1);
    checkOutput("writeEnCycles", weCnt, doWrite ? XLEN : 0);
    checkOutput("busyGap", busyLow, 0);
    @(negedge clk);
    checkOutput("idleAfterDone", {29'd0, busy, done, writeEn}, 32'd0);
    if (doWrite) expRegs[d] = result;
    checkOutput("rdValue", regs[d], expRegs[d]);
    diff = 0;
    for (int i = 0; i < NREG; i++) if (regs[i] !== expRegs[i]) diff++;
    checkOutput("regfileImage", diff, 0);
  endtask

  // start held high: one operation per visit to IDLE, dones at 65, 131, 197
  task automatic heldStart();
    int doneCnt, firstDone, lastDone;
    logic [XLEN-1:0] result;
    doneCnt = 0; firstDone = 0; lastDone = 0;
    result = expRegs[1] ^ expRegs[2];
    aluSel = 0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd6; wb_en = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      @(negedge clk);
      if (cyc == 136) start = 1'b0;
      if (done) begin
        doneCnt++;
        if (firstDone == 0) firstDone = cyc;
        lastDone = cyc;
      end
    end
    expRegs[6] = result;
    checkOutput("heldDoneCount", doneCnt, 3);
    checkOutput("heldFirstDone", firstDone, LAT_FULL);
    checkOutput("heldLastDone", lastDone, 3 * LAT_FULL + 2);
    checkOutput("heldReg6", regs[6], expRegs[6]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0; rd = '0; wb_en = 1'b0;
    randomSeeds();
    #1;
    checkOutput("resetOutputs", {11'd0, regA_select, regB_select, bitPos, writeEn, data_in,
                                 bit_first, bit_last, busy, done}, 32'd0);
    @(negedge clk);
    loadSeeds();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idleOutputs", {11'd0, regA_select, regB_select, bitPos, writeEn, data_in,
                                bit_first, bit_last, busy, done}, 32'd0);

    expRegs[3] = 32'h0000FFFF;
    expRegs[4] = 32'h00FF00FF;
    loadSeeds();
    applyStimulus(5'd3, 5'd4, 5'd5, 1'b1, 0, 0);
    checkOutput("reg5Xor", regs[5], 32'h00FFFF00);

    applyStimulus(5'd2, 5'd3, 5'd0, 1'b1, 0, 0);
    checkOutput("reg0Zero", regs[0], 32'd0);

    expRegs[7] = 32'h80000001;
    loadSeeds();
    applyStimulus(5'd7, 5'd1, 5'd7, 1'b1, 1, 0);
    checkOutput("reg7Pass", regs[7], 32'h80000001);
    applyStimulus(5'd7, 5'd8, 5'd7, 1'b1, 0, 0);

    expRegs[9] = 32'hDEADBEEF;
    loadSeeds();
    applyStimulus(5'd1, 5'd2, 5'd9, 1'b0, 0, 0);
    checkOutput("reg9Kept", regs[9], 32'hDEADBEEF);

    applyStimulus(5'd3, 5'd4, 5'd10, 1'b1, 0, 40);
    randomSeeds();
    loadSeeds();
    applyStimulus(5'd3, 5'd4, 5'd10, 1'b1, 2, 0);

    heldStart();

    for (int n = 0; n < 12; n++) begin
      applyStimulus(SEL_W'($urandom), SEL_W'($urandom), SEL_W'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
